branch_predictor_unit: RTL and testbench
========================================

Name: branch_predictor_unit

Overview:
- Branch prediction responder for the pipelined MIPS core.
- Fetch stage presents the PC and receives a taken/not-taken prediction plus a predicted target in the same cycle.
- Execute stage returns the resolved outcome on the update interface (update_signal_E, actual_outcome_E, prediction_E); the block trains its tables and reports mispredictions for the core's flush logic.
- Sits beside the fetch PC mux; the pipeline carries the prediction to E.

Parameters:
- PC_W, 5, width of PC and branch target.
- IDX_W, 4, index width; table depth is 2**IDX_W entries.
- GHR_W, 4, global history length (used only with GSHARE_EN); must be <= IDX_W.
- STAT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- pc_F  in  PC_W  fetch PC.
- prediction_F  out  1  predict taken; combinational from pc_F.
- target_F  out  PC_W  predicted target; combinational; valid only when prediction_F=1, else 0.
- update_signal_E  in  1  a branch resolved in E this cycle.
- pc_E  in  PC_W  PC of the resolving branch.
- actual_outcome_E  in  1  resolved direction (1 = taken).
- prediction_E  in  1  prediction that travelled with the branch.
- target_E  in  PC_W  resolved branch target.
- mispredict_E  out  1  combinational: update_signal_E & (actual_outcome_E != prediction_E).
- branch_count  out  STAT_W  resolved branches, saturating.
- mispredict_count  out  STAT_W  mispredictions, saturating.

Behaviour:
- Tables, per entry: 2-bit counter, valid bit, tag = pc[PC_W-1:IDX_W], target (PC_W).
- Counter encoding: SN=00, WN=01, WT=10, ST=11.
- Taken increments the counter, saturating at ST. Not-taken decrements it, saturating at SN.
- Lookup index (no GSHARE_EN): pc_F[IDX_W-1:0].
- Hit = valid & tag match. prediction_F = hit & counter[1]. target_F = stored target when prediction_F is 1, else 0.
- Update on a rising edge with reset=1 and update_signal_E=1, at index pc_E[IDX_W-1:0]:
  - On tag miss or invalid entry: counter initialises to WT if actual_outcome_E=1, else WN. Tag is written and valid is set.
  - On hit: counter steps as above.
  - Target is written only when actual_outcome_E=1.
- Same-cycle lookup and update to the same index: lookup returns the pre-update (old) state. No bypass.
- Statistics:
  - branch_count increments on every update.
  - mispredict_count increments when mispredict_E=1.
  - Both hold at all-ones.
- Reset (reset=0 at an edge), including mid-operation:
  - All valid bits cleared, all counters set to WN, targets and tags cleared to 0.
  - GHR cleared to 0; branch_count and mispredict_count set to 0.
  - update_signal_E is ignored in the same cycle.
  - prediction_F and target_F read 0 in the cycle after reset.
- Latency: prediction is 0-cycle combinational. Training becomes visible on the cycle after the update edge.

Optional Feature:
- Macro: BP_GSHARE_EN.
- With it defined:
  - A GHR_W-bit global history register shifts in actual_outcome_E (LSB = newest) on every update.
  - Counter index = pc[IDX_W-1:0] XOR zero-extended GHR, for both lookup and update.
  - The update uses the GHR value before the shift.
  - Tag/valid/target arrays stay PC-indexed.
- Without it: no GHR exists, and counters are PC-indexed as above.

Decomposition:
- Shared package bp_pkg:
  - Counter encoding typedef (SN/WN/WT/ST).
  - Reset counter constant WN.
  - Default width localparams.
  - Function next_counter(counter, taken).
- One natural sub-module: bp_sat_counter, a STAT_W saturating incrementer with sync active-low clear, instantiated twice for the statistics counters.

Test Plan:
- Reset, then pc_F=5'h03 → prediction_F=0, target_F=0. branch_count=0, mispredict_count=0.
- Update pc_E=5'h03, taken, target_E=5'h10, prediction_E=0, then lookup 5'h03 → mispredict_E=1 during update; next cycle prediction_F=1, target_F=5'h10, mispredict_count=1.
- Three not-taken updates at 5'h03 after the above → counter WT→WN→SN→SN; prediction_F=0 after the first.
- Aliasing: train 5'h03 taken, then look up 5'h13 → tag miss, prediction_F=0. Then update 5'h13 not-taken → entry retagged; lookup 5'h03 → 0.
- Same-cycle pc_F=pc_E=5'h07 on first taken update → prediction_F=0 in that cycle, 1 on the next.
- Preload branch_count to all-ones (force), apply an update → stays 16'hFFFF.
- BP_GSHARE_EN only: history 4'b0001, branch at pc 5'h02 → trains counter index 4'h3, not 4'h2.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor.
//   - ctr_t       : 2-bit direction counter encoding (SN/WN/WT/ST)
//   - CTR_RESET   : counter value loaded on reset (weakly not-taken)
//   - *_DEF       : default widths for the predictor parameters
//   - next_counter: saturating step of a direction counter
package bp_pkg;

  localparam int unsigned PC_W_DEF   = 5;
  localparam int unsigned IDX_W_DEF  = 4;
  localparam int unsigned GHR_W_DEF  = 4;
  localparam int unsigned STAT_W_DEF = 16;

  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WN;

  function automatic ctr_t next_counter(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != SN) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: W-bit incrementer that holds at all-ones.
//   clk_i   : clock
//   clr_ni  : synchronous active-low clear (wins over inc_i)
//   inc_i   : increment request
//   count_o : current count
module bp_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor_unit.sv
// branch_predictor_unit: 2-bit-counter branch predictor with tagged entries
// and a per-entry target, plus saturating branch/mispredict statistics.
//   clk, reset (sync, active-low)
//   pc_F -> prediction_F, target_F            : combinational fetch lookup
//   update_signal_E, pc_E, actual_outcome_E,
//   prediction_E, target_E                    : execute-stage training
//   mispredict_E                              : combinational mispredict flag
//   branch_count, mispredict_count            : saturating statistics
// Optional: define BP_GSHARE_EN to XOR a global history register into the
// counter index (tag/valid/target arrays stay PC-indexed).
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned GHR_W  = GHR_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_F,
  output logic              prediction_F,
  output logic [PC_W-1:0]   target_F,
  input  logic              update_signal_E,
  input  logic [PC_W-1:0]   pc_E,
  input  logic              actual_outcome_E,
  input  logic              prediction_E,
  input  logic [PC_W-1:0]   target_E,
  output logic              mispredict_E,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = PC_W - IDX_W;

  if (GHR_W > IDX_W) begin : g_bad_ghr
    $error("GHR_W must not exceed IDX_W");
  end

  ctr_t             cnt_q   [DEPTH];
  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [PC_W-1:0]  tgt_q   [DEPTH];

  logic [IDX_W-1:0] f_idx, e_idx, f_cidx, e_cidx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  ctr_t             cnt_d;

  assign f_idx = pc_F[IDX_W-1:0];
  assign e_idx = pc_E[IDX_W-1:0];
  assign f_tag = pc_F[PC_W-1:IDX_W];
  assign e_tag = pc_E[PC_W-1:IDX_W];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Both lookup and update use the history as it stands before this edge.
  assign f_cidx = f_idx ^ IDX_W'(ghr_q);
  assign e_cidx = e_idx ^ IDX_W'(ghr_q);
  assign ghr_d  = GHR_W'({ghr_q, actual_outcome_E});

  always_ff @(posedge clk) begin
    if (!reset)               ghr_q <= '0;
    else if (update_signal_E) ghr_q <= ghr_d;
  end
`else
  assign f_cidx = f_idx;
  assign e_cidx = e_idx;
`endif

  assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign prediction_F = f_hit && (cnt_q[f_cidx] inside {WT, ST});
  assign target_F     = prediction_F ? tgt_q[f_idx] : '0;

  assign e_hit        = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign mispredict_E = update_signal_E && (actual_outcome_E != prediction_E);

  // A fresh allocation starts on the weak side of the resolved direction.
  always_comb begin
    cnt_d = actual_outcome_E ? WT : WN;
    if (e_hit) cnt_d = next_counter(cnt_q[e_cidx], actual_outcome_E);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cnt_q[i]   <= CTR_RESET;
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else if (update_signal_E) begin
      cnt_q[e_cidx]  <= cnt_d;
      valid_q[e_idx] <= 1'b1;
      tag_q[e_idx]   <= e_tag;
      if (actual_outcome_E) tgt_q[e_idx] <= target_E;
    end
  end

  bp_sat_counter #(.W(STAT_W)) u_branch_cnt (
    .clk_i   (clk),
    .clr_ni  (reset),
    .inc_i   (update_signal_E),
    .count_o (branch_count)
  );

  bp_sat_counter #(.W(STAT_W)) u_mispredict_cnt (
    .clk_i   (clk),
    .clr_ni  (reset),
    .inc_i   (mispredict_E),
    .count_o (mispredict_count)
  );

endmodule

// File: tb/tb_branch_predictor_unit.sv
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  pc_F;
  logic        prediction_F;
  logic [4:0]  target_F;
  logic        update_signal_E;
  logic [4:0]  pc_E;
  logic        actual_outcome_E;
  logic        prediction_E;
  logic [4:0]  target_E;
  logic        mispredict_E;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  branch_predictor_unit dut (
    .clk              (clk),
    .reset            (reset),
    .pc_F             (pc_F),
    .prediction_F     (prediction_F),
    .target_F         (target_F),
    .update_signal_E  (update_signal_E),
    .pc_E             (pc_E),
    .actual_outcome_E (actual_outcome_E),
    .prediction_E     (prediction_E),
    .target_E         (target_E),
    .mispredict_E     (mispredict_E),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tables held as plain integers.
  int m_cnt[16];
  bit m_val[16];
  int m_tag[16];
  int m_tgt[16];
  int m_ghr;
  int m_bc;
  int m_mc;

  function automatic int m_cidx(input int pc);
`ifdef BP_GSHARE_EN
    return (pc % 16) ^ m_ghr;
`else
    return pc % 16;
`endif
  endfunction

  function automatic bit m_hit(input int pc);
    return m_val[pc % 16] && (m_tag[pc % 16] == pc / 16);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        m_cnt[i] = 1; m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
      end
      m_ghr = 0; m_bc = 0; m_mc = 0;
    end else if (update_signal_E) begin
      int pc, pi, ci;
      bit t;
      pc = int'(pc_E); pi = pc % 16; ci = m_cidx(pc); t = actual_outcome_E;
      if (!m_hit(pc)) m_cnt[ci] = t ? 2 : 1;
      else if (t)     m_cnt[ci] = (m_cnt[ci] == 3) ? 3 : m_cnt[ci] + 1;
      else            m_cnt[ci] = (m_cnt[ci] == 0) ? 0 : m_cnt[ci] - 1;
      m_val[pi] = 1;
      m_tag[pi] = pc / 16;
      if (t) m_tgt[pi] = int'(target_E);
`ifdef BP_GSHARE_EN
      m_ghr = ((m_ghr * 2) + (t ? 1 : 0)) % 16;
`endif
      if (m_bc < 65535) m_bc++;
      if ((actual_outcome_E != prediction_E) && (m_mc < 65535)) m_mc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int pc;
      bit ep;
      bit em;
      pc = int'(pc_F);
      ep = m_hit(pc) && (m_cnt[m_cidx(pc)] >= 2);
      em = update_signal_E && (actual_outcome_E != prediction_E);
      check("model_prediction_F", prediction_F, ep);
      check("model_target_F", target_F, ep ? m_tgt[pc % 16] : 0);
      check("model_mispredict_E", mispredict_E, em);
      check("model_branch_count", branch_count, m_bc);
      check("model_mispredict_count", mispredict_count, m_mc);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int pce, input bit act, input bit pe, input int tge);
    logic [4:0] a, b;
    a = pce[4:0]; b = tge[4:0];
    update_signal_E = 1'b1; pc_E = a; actual_outcome_E = act;
    prediction_E = pe; target_E = b;
  endtask

  task automatic idle();
    update_signal_E = 1'b0;
  endtask

  initial begin
    reset = 1'b0; pc_F = '0; update_signal_E = 1'b0; pc_E = '0;
    actual_outcome_E = 1'b0; prediction_E = 1'b0; target_E = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cmp_en = 1;
    pc_F = 5'h03;
    @(negedge clk);
    check("rst_pred", prediction_F, 0);
    check("rst_target", target_F, 0);
    check("rst_bc", branch_count, 0);
    check("rst_mc", mispredict_count, 0);

`ifndef BP_GSHARE_EN
    nxt(); upd(5'h03, 1, 0, 5'h10);
    @(negedge clk);
    check("first_upd_mispredict", mispredict_E, 1);
    nxt(); idle(); pc_F = 5'h03;
    @(negedge clk);
    check("trained_pred", prediction_F, 1);
    check("trained_target", target_F, 5'h10);
    check("trained_mc", mispredict_count, 1);
    check("trained_bc", branch_count, 1);

    for (int k = 0; k < 3; k++) begin
      nxt(); upd(5'h03, 0, 0, 5'h00);
      nxt(); idle();
      @(negedge clk);
      check("nt_step_pred", prediction_F, 0);
    end

    // SN -> WN -> WT
    nxt(); upd(5'h03, 1, 0, 5'h10);
    nxt(); upd(5'h03, 1, 0, 5'h10);
    nxt(); idle(); pc_F = 5'h03;
    @(negedge clk);
    check("retrain_pred", prediction_F, 1);
    pc_F = 5'h13;
    @(negedge clk);
    check("alias_miss_pred", prediction_F, 0);
    nxt(); upd(5'h13, 0, 0, 5'h00);
    nxt(); idle(); pc_F = 5'h03;
    @(negedge clk);
    check("alias_retag_pred", prediction_F, 0);
    check("alias_retag_target", target_F, 0);

    nxt(); upd(5'h07, 1, 0, 5'h1A); pc_F = 5'h07;
    @(negedge clk);
    check("same_cycle_old_pred", prediction_F, 0);
    nxt(); idle();
    @(negedge clk);
    check("same_cycle_next_pred", prediction_F, 1);
    check("same_cycle_next_target", target_F, 5'h1A);
`else
    // History 0 trains counter 0; history 4'b0001 at pc 02 trains counter 3.
    nxt(); upd(5'h00, 1, 0, 5'h05);
    nxt(); upd(5'h02, 1, 0, 5'h09);
    nxt(); idle(); pc_F = 5'h00;
    @(negedge clk);
    check("gshare_idx3_pred", prediction_F, 1);
    check("gshare_idx3_target", target_F, 5'h05);
    pc_F = 5'h02;
    @(negedge clk);
    check("gshare_pc2_pred", prediction_F, 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      nxt();
      reset = ($urandom_range(0, 199) != 0);
      update_signal_E = 1'($urandom_range(0, 1));
      pc_E = 5'($urandom_range(0, 31));
      actual_outcome_E = 1'($urandom_range(0, 1));
      prediction_E = 1'($urandom_range(0, 1));
      target_E = 5'($urandom_range(0, 31));
      pc_F = ($urandom_range(0, 3) == 0) ? pc_E : 5'($urandom_range(0, 31));
    end

    // Continuous updates drive branch_count into saturation.
    reset = 1'b1;
    for (int n = 0; n < 65600; n++) begin
      nxt();
      update_signal_E = 1'b1;
      pc_E = 5'($urandom_range(0, 31));
      actual_outcome_E = 1'($urandom_range(0, 1));
      prediction_E = ($urandom_range(0, 7) == 0) ? ~actual_outcome_E : actual_outcome_E;
      target_E = 5'($urandom_range(0, 31));
      pc_F = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    check("bc_saturated", branch_count, 16'hFFFF);
    nxt();
    @(negedge clk);
    check("bc_holds", branch_count, 16'hFFFF);

    // Reset with a concurrent update: the update must be dropped.
    nxt(); reset = 1'b0; upd(5'h03, 1, 0, 5'h11);
    nxt(); reset = 1'b1; idle(); pc_F = 5'h03;
    @(negedge clk);
    check("midrst_bc", branch_count, 0);
    check("midrst_mc", mispredict_count, 0);
    check("midrst_pred", prediction_F, 0);
    check("midrst_target", target_F, 0);

    nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
